sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Shares the single SRAM controller between two requesters: port 0, the data-cache miss/write-through path, and port 1, the memory-image loader/debug path. Round-robin arbitration over whole transactions. Latches the winning command, drives the SRAM controller enables, and routes the 64-bit read data and a per-port ready back to the winner. Sits between the cache controller, the loader and the SRAM controller in the memory stage.

Parameters:
ADDR_W, 32, byte address width on every port
DATA_W, 32, write-data width
RDATA_W, 64, read-data width returned by the SRAM controller
TIMEOUT_CYC, 255, watchdog limit in cycles; used only with the optional feature

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (0 = reset)
wrEn0, rdEn0  in  1 each  port-0 write/read request, level, held until ready0
address0  in  ADDR_W  port-0 address
writeData0  in  DATA_W  port-0 write data
readData0  out  RDATA_W  port-0 read data, registered
ready0  out  1  port-0 ready; low = stall requester
wrEn1, rdEn1, address1, writeData1, readData1, ready1  as port 0, for port 1
sramWrEn, sramRdEn  out  1 each  to SRAM controller, registered
sramAddress  out  ADDR_W  latched address
sramWriteData  out  DATA_W  latched write data
sramReadData  in  RDATA_W  from SRAM controller
sramReady  in  1  SRAM controller ready; low while busy
timeoutErr  out  1  watchdog abort pulse (optional feature)

Behaviour:
- reqN = wrEnN | rdEnN. If both wrEnN and rdEnN are set, write wins.
- States: IDLE, BUSY, RELEASE.
- Reset (rst=0, asynchronous): state=IDLE; sramWrEn=sramRdEn=0; sramAddress=sramWriteData=0; readData0=readData1=0; done0=done1=0; lastGrant=1, so port 0 wins first; timeoutErr=0. Reset in mid-transaction drops the SRAM enables immediately. The in-flight transaction is lost and is not replayed.
- IDLE: when any reqN=1, pick the winner:
  - only one requesting: that port wins.
  - both requesting: the port other than lastGrant wins.
  - On the next edge: latch address/data/op into the sram* registers, assert exactly one of sramWrEn/sramRdEn, set grant and lastGrant to the winner, clear the first flag, go to BUSY.
- BUSY:
  - The SRAM enables stay constant.
  - sramReady is ignored in the first BUSY cycle, while the controller is still observing the enable.
  - In any later cycle with sramReady=1: drop both enables, capture sramReadData into readData[grant] (reads only; writes leave it unchanged), set done[grant]=1, go to RELEASE.
- RELEASE: lasts one cycle with the enables low. doneN is cleared at the end of the cycle, then the state returns to IDLE. Requests are not sampled in RELEASE.
- readyN = ~reqN | doneN (combinational from registered done).
  - An idle port reads ready.
  - A requesting port stalls until its done cycle.
  - The requester advances on the edge that ends RELEASE, so a held request is never executed twice.
- Latency for an SRAM controller that is busy K cycles (sramReady low for K cycles starting 1 cycle after the enable):
  - request seen in IDLE at cycle 0
  - enables asserted cycles 1..K+1
  - readyN=1 at cycle K+2
  - next grant possible at cycle K+3
- A request withdrawn during BUSY still completes; the done pulse is harmless because readyN is already 1.
- The loser's request is held and granted in the next IDLE. There is no starvation: with both ports requesting continuously, grants strictly alternate.
- sramAddress and sramWriteData are not modified outside IDLE→BUSY.

Optional Feature:
Macro SRAM_ARB_TIMEOUT_EN.
- Defined: an 8-bit-or-wider counter clears on entry to BUSY and increments each BUSY cycle. When it reaches TIMEOUT_CYC without sramReady, the arbiter:
  - drops the enables
  - forces readData[grant] to all ones
  - pulses done[grant] and timeoutErr for one cycle
  - goes to RELEASE
- Not defined: no counter; BUSY waits indefinitely; timeoutErr is tied to 0.

Test Plan:
- Reset: rst=0 mid-BUSY with sramRdEn=1 -> sramRdEn=0 in the same cycle; ready0=ready1=1 with no requests; readData0/1=0.
- Single read: rdEn0=1, address0=0x0000_0400, controller returns 0x1122334455667788 after K=5 -> sramRdEn high cycles 1..6; ready0 low until cycle 7; readData0=0x1122334455667788 at cycle 7.
- Single write: wrEn1=1, address1=0x10, writeData1=0xDEADBEEF -> sramWrEn=1, sramAddress=0x10, sramWriteData=0xDEADBEEF; ready1 pulses; readData1 unchanged.
- Contention: both ports read continuously for 4 transactions -> grant order 0,1,0,1 after reset; no request executed twice (count sramRdEn rising edges = 4).
- Stall during other grant: port 1 requests while port 0 is in BUSY -> ready1 stays low until its own done; port 1 is granted in the first IDLE after RELEASE.
- Timeout (SRAM_ARB_TIMEOUT_EN, TIMEOUT_CYC=16): sramReady held low -> after 16 BUSY cycles timeoutErr=1 for one cycle, readData0=all ones, ready0 pulses, FSM back in IDLE.

Source files
------------

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Brief    : Round-robin, whole-transaction arbiter that shares one SRAM
//            controller between the data-cache path (port 0) and the
//            loader/debug path (port 1). Optional watchdog: SRAM_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int RDATA_W     = 64,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrEn0,
    input  logic               rdEn0,
    input  logic [ADDR_W-1:0]  address0,
    input  logic [DATA_W-1:0]  writeData0,
    output logic [RDATA_W-1:0] readData0,
    output logic               ready0,
    input  logic               wrEn1,
    input  logic               rdEn1,
    input  logic [ADDR_W-1:0]  address1,
    input  logic [DATA_W-1:0]  writeData1,
    output logic [RDATA_W-1:0] readData1,
    output logic               ready1,
    output logic               sramWrEn,
    output logic               sramRdEn,
    output logic [ADDR_W-1:0]  sramAddress,
    output logic [DATA_W-1:0]  sramWriteData,
    input  logic [RDATA_W-1:0] sramReadData,
    input  logic               sramReady,
    output logic               timeoutErr
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t             r_state;
    logic               r_grant;
    logic               r_last_grant;
    logic               r_busy_seen;
    logic               r_done0;
    logic               r_done1;

    logic               w_req0;
    logic               w_req1;
    logic               w_pick1;
    logic               w_sel_wr;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_data;
    logic               w_finish;
    logic               w_expire;

    if (TIMEOUT_CYC < 1) begin : g_timeout_check
        $error("sram_arbiter: TIMEOUT_CYC must be at least 1");
    end

    assign w_req0 = wrEn0 | rdEn0;
    assign w_req1 = wrEn1 | rdEn1;

    // On contention the port that did not win last time is served.
    assign w_pick1    = w_req1 & (~w_req0 | ~r_last_grant);
    assign w_sel_wr   = w_pick1 ? wrEn1      : wrEn0;
    assign w_sel_addr = w_pick1 ? address1   : address0;
    assign w_sel_data = w_pick1 ? writeData1 : writeData0;

    // The controller is still sampling the enable during the first BUSY cycle.
    assign w_finish = r_busy_seen & sramReady;

    assign ready0 = ~w_req0 | r_done0;
    assign ready1 = ~w_req1 | r_done1;

`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYC) > 8) ? $clog2(TIMEOUT_CYC) : 8;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);

    logic [c_CNT_W-1:0] r_timer;
    logic               r_timeout_err;

    assign w_expire   = ~w_finish & (r_timer == c_CNT_LAST);
    assign timeoutErr = r_timeout_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= (r_state == ST_BUSY) & w_expire;
            if (r_state == ST_BUSY) begin
                r_timer <= r_timer + 1'b1;
            end else begin
                r_timer <= '0;
            end
        end
    end
`else
    assign w_expire   = 1'b0;
    assign timeoutErr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_grant       <= 1'b0;
            r_last_grant  <= 1'b1;
            r_busy_seen   <= 1'b0;
            r_done0       <= 1'b0;
            r_done1       <= 1'b0;
            sramWrEn      <= 1'b0;
            sramRdEn      <= 1'b0;
            sramAddress   <= '0;
            sramWriteData <= '0;
            readData0     <= '0;
            readData1     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_req0 | w_req1) begin
                        sramAddress   <= w_sel_addr;
                        sramWriteData <= w_sel_data;
                        sramWrEn      <= w_sel_wr;
                        sramRdEn      <= ~w_sel_wr;
                        r_grant       <= w_pick1;
                        r_last_grant  <= w_pick1;
                        r_busy_seen   <= 1'b0;
                        r_state       <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    r_busy_seen <= 1'b1;
                    if (w_finish | w_expire) begin
                        sramWrEn <= 1'b0;
                        sramRdEn <= 1'b0;
                        if (r_grant) begin
                            r_done1 <= 1'b1;
                            if (w_expire) begin
                                readData1 <= '1;
                            end else if (sramRdEn) begin
                                readData1 <= sramReadData;
                            end
                        end else begin
                            r_done0 <= 1'b1;
                            if (w_expire) begin
                                readData0 <= '1;
                            end else if (sramRdEn) begin
                                readData0 <= sramReadData;
                            end
                        end
                        r_state <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    r_done0 <= 1'b0;
                    r_done1 <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// Self-checking bench for sram_arbiter: transaction-level latency model,
// per-cycle comparison, and directed cases with literal expectations.
module tb_sram_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int RW = 64;
    localparam int TO = 16;
`ifdef SRAM_ARB_TIMEOUT_EN
    localparam int TO_LIM = TO;
`else
    localparam int TO_LIM = 1 << 30;
`endif

    typedef struct {
        bit          we;
        logic [31:0] a;
        logic [31:0] d;
        int          gap;
    } op_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    wr_en = '0;
    logic [1:0]    rd_en = '0;
    logic [AW-1:0] addr [2] = '{default: '0};
    logic [DW-1:0] wdata[2] = '{default: '0};
    logic [RW-1:0] readData0, readData1, sramReadData;
    logic          ready0, ready1, sramWrEn, sramRdEn, sramReady, timeoutErr;
    logic [AW-1:0] sramAddress;
    logic [DW-1:0] sramWriteData;

    int  checks = 0;
    int  failures = 0;
    int  cyc = 0;
    int  k_lat = 1;
    int  busy_cnt = 0;
    int  rd_rises = 0;
    int  grant_log[$];
    op_t q[2][$];

    sram_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .RDATA_W(RW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .wrEn0(wr_en[0]), .rdEn0(rd_en[0]), .address0(addr[0]), .writeData0(wdata[0]),
        .readData0(readData0), .ready0(ready0),
        .wrEn1(wr_en[1]), .rdEn1(rd_en[1]), .address1(addr[1]), .writeData1(wdata[1]),
        .readData1(readData1), .ready1(ready1),
        .sramWrEn(sramWrEn), .sramRdEn(sramRdEn), .sramAddress(sramAddress),
        .sramWriteData(sramWriteData), .sramReadData(sramReadData),
        .sramReady(sramReady), .timeoutErr(timeoutErr)
    );

    function automatic logic [63:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0400) return 64'h1122_3344_5566_7788;
        return {a ^ 32'hA5A5_A5A5, ~a};
    endfunction

    // SRAM controller: busy for k_lat cycles once it sees an enable.
    assign sramReady    = (sramRdEn | sramWrEn) && (busy_cnt >= k_lat);
    assign sramReadData = mem_word(sramAddress);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        busy_cnt <= (sramRdEn | sramWrEn) ? busy_cnt + 1 : 0;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s cycle=%0d got=timeout expected=event", name, cyc);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_req(input int p, output int t);
        t = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (rd_en[p] | wr_en[p]) begin
                t = cyc;
                break;
            end
        end
        if (t < 0) begin
            fail_timeout("wait_req");
            t = cyc;
        end
    endtask

    // Requesters: hold each op until ready is seen, then move to the next.
    initial begin : driver
        logic [1:0] fin;
        op_t        op;
        forever begin
            @(negedge clk);
            fin = {ready1 & (rd_en[1] | wr_en[1]), ready0 & (rd_en[0] | wr_en[0])};
            @(posedge clk);
            #1;
            if (!rst) begin
                rd_en = '0;
                wr_en = '0;
                q[0].delete();
                q[1].delete();
            end else begin
                for (int p = 0; p < 2; p++) begin
                    if (fin[p]) begin
                        rd_en[p] = 1'b0;
                        wr_en[p] = 1'b0;
                    end
                    if (!(rd_en[p] | wr_en[p]) && q[p].size() > 0) begin
                        if (q[p][0].gap > 0) begin
                            q[p][0].gap = q[p][0].gap - 1;
                        end else begin
                            op       = q[p].pop_front();
                            rd_en[p] = !op.we;
                            wr_en[p] = op.we;
                            addr[p]  = op.a;
                            wdata[p] = op.d;
                        end
                    end
                end
            end
        end
    end

    // Transaction model: a request seen at cycle s (port free) holds the
    // enables for s+1..s+L, completes at s+L+1, next grant from s+L+2.
    initial begin : model
        bit          m_act, m_we, m_to, in_busy, done_now, prev_rd;
        int          m_s, m_end, m_free, m_port, m_last, k, win;
        logic [31:0] m_addr, m_wdata;
        logic [63:0] exp_rd[2];
        m_act = 0; m_we = 0; m_to = 0; prev_rd = 0;
        m_s = 0; m_end = 0; m_free = 0; m_port = 0; m_last = 1;
        m_addr = '0; m_wdata = '0; exp_rd[0] = '0; exp_rd[1] = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_act = 0; m_free = 0; m_last = 1; prev_rd = 0;
                m_addr = '0; m_wdata = '0; exp_rd[0] = '0; exp_rd[1] = '0;
            end else begin
                in_busy  = m_act && cyc > m_s && cyc < m_end;
                done_now = m_act && cyc == m_end;
                if (done_now) begin
                    if (m_to) exp_rd[m_port] = '1;
                    else if (!m_we) exp_rd[m_port] = mem_word(m_addr);
                end
                chk("sramWrEn", sramWrEn, in_busy && m_we);
                chk("sramRdEn", sramRdEn, in_busy && !m_we);
                chk("sramAddress", sramAddress, m_addr);
                chk("sramWriteData", sramWriteData, m_wdata);
                chk("ready0", ready0, !(rd_en[0] | wr_en[0]) || (done_now && m_port == 0));
                chk("ready1", ready1, !(rd_en[1] | wr_en[1]) || (done_now && m_port == 1));
                chk("readData0", readData0, exp_rd[0]);
                chk("readData1", readData1, exp_rd[1]);
                chk("timeoutErr", timeoutErr, done_now && m_to);
                if (sramRdEn && !prev_rd) begin
                    rd_rises++;
                    grant_log.push_back(int'(sramAddress[9]));
                end
                prev_rd = sramRdEn;
                if (cyc >= m_free && ((rd_en | wr_en) != 2'b00)) begin
                    if ((rd_en[0] | wr_en[0]) && (rd_en[1] | wr_en[1])) win = 1 - m_last;
                    else win = (rd_en[1] | wr_en[1]) ? 1 : 0;
                    k       = k_lat;
                    m_to    = (k + 1) > TO_LIM;
                    m_act   = 1;
                    m_s     = cyc;
                    m_end   = cyc + (m_to ? TO_LIM : k + 1) + 1;
                    m_free  = m_end + 1;
                    m_port  = win;
                    m_last  = win;
                    m_we    = wr_en[win];
                    m_addr  = addr[win];
                    m_wdata = wdata[win];
                end
            end
        end
    end

    initial begin : main
        int t0, base, g;
        int exp_order[4] = '{0, 1, 0, 1};

        repeat (3) @(negedge clk);
        chk("rst_ready0", ready0, 1);
        chk("rst_ready1", ready1, 1);
        chk("rst_readData0", readData0, 0);
        chk("rst_sramRdEn", sramRdEn, 0);
        #2 rst = 1'b1;

        // single read, K=5
        k_lat = 5;
        q[0].push_back('{we: 0, a: 32'h0000_0400, d: 32'h0, gap: 0});
        wait_req(0, t0);
        for (int c = 1; c <= 6; c++) begin
            wait_cyc(t0 + c);
            chk("rd_en_window", sramRdEn, 1);
            chk("rd_stall", ready0, 0);
        end
        wait_cyc(t0 + 7);
        chk("rd_ready", ready0, 1);
        chk("rd_data", readData0, 64'h1122_3344_5566_7788);
        chk("rd_en_drop", sramRdEn, 0);
        repeat (3) @(negedge clk);

        // single write on port 1, K=3
        k_lat = 3;
        q[1].push_back('{we: 1, a: 32'h10, d: 32'hDEAD_BEEF, gap: 0});
        wait_req(1, t0);
        wait_cyc(t0 + 1);
        chk("wr_en", sramWrEn, 1);
        chk("wr_addr", sramAddress, 32'h10);
        chk("wr_data", sramWriteData, 32'hDEAD_BEEF);
        wait_cyc(t0 + 4);
        chk("wr_stall", ready1, 0);
        wait_cyc(t0 + 5);
        chk("wr_ready", ready1, 1);
        chk("wr_readData1", readData1, 0);
        repeat (3) @(negedge clk);

        // port 1 arrives while port 0 is busy, K=4
        k_lat = 4;
        q[0].push_back('{we: 0, a: 32'h180, d: 32'h0, gap: 0});
        q[1].push_back('{we: 0, a: 32'h280, d: 32'h0, gap: 2});
        wait_req(0, t0);
        wait_cyc(t0 + 6);
        chk("stall_ready0", ready0, 1);
        chk("stall_ready1", ready1, 0);
        wait_cyc(t0 + 8);
        chk("stall_grant1_en", sramRdEn, 1);
        chk("stall_grant1_addr", sramAddress, 32'h280);
        wait_cyc(t0 + 13);
        chk("stall_ready1_done", ready1, 1);
        repeat (3) @(negedge clk);

`ifdef SRAM_ARB_TIMEOUT_EN
        k_lat = 100;
        q[0].push_back('{we: 0, a: 32'h40, d: 32'h0, gap: 0});
        wait_req(0, t0);
        wait_cyc(t0 + 16);
        chk("to_still_busy", sramRdEn, 1);
        wait_cyc(t0 + 17);
        chk("to_err", timeoutErr, 1);
        chk("to_data", readData0, {64{1'b1}});
        chk("to_ready", ready0, 1);
        wait_cyc(t0 + 18);
        chk("to_err_pulse", timeoutErr, 0);
        repeat (3) @(negedge clk);
`endif

        // asynchronous reset in the middle of a read
        k_lat = 20;
        q[0].push_back('{we: 0, a: 32'h300, d: 32'h0, gap: 0});
        wait_req(0, t0);
        wait_cyc(t0 + 3);
        chk("pre_rst_rden", sramRdEn, 1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_rden", sramRdEn, 0);
        chk("async_rst_rd0", readData0, 0);
        chk("async_rst_rd1", readData1, 0);
        repeat (2) @(negedge clk);
        chk("rst_idle_ready0", ready0, 1);
        chk("rst_idle_ready1", ready1, 1);
        #2 rst = 1'b1;

        // contention from reset: grants must alternate 0,1,0,1
        k_lat = 2;
        base  = grant_log.size();
        q[0].push_back('{we: 0, a: 32'h100, d: 32'h0, gap: 0});
        q[0].push_back('{we: 0, a: 32'h104, d: 32'h0, gap: 0});
        q[1].push_back('{we: 0, a: 32'h200, d: 32'h0, gap: 0});
        q[1].push_back('{we: 0, a: 32'h204, d: 32'h0, gap: 0});
        repeat (2) @(negedge clk);
        t0 = cyc;
        while ((q[0].size() > 0 || q[1].size() > 0 || (rd_en | wr_en) != 2'b00) && cyc < t0 + 200)
            @(negedge clk);
        if (cyc >= t0 + 200) fail_timeout("contention_drain");
        repeat (2) @(negedge clk);
        chk("contention_rises", grant_log.size() - base, 4);
        for (int i = 0; i < 4; i++) begin
            g = (base + i < grant_log.size()) ? grant_log[base + i] : 99;
            chk("contention_order", g, exp_order[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog cycle=%0d got=running expected=finished", cyc);
        $fatal(1, "bench time limit reached");
    end

endmodule
`default_nettype wire
